// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_resp_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned MAX_WAIT   = 15;
    localparam int unsigned CNT_W      = $clog2(MAX_WAIT + 1);

    // Value loaded into the wait counter on accept; zero when no wait states are modelled.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
        logic [CNT_W-1:0] val;
        val = '0;
        if (wait_cycles > 0) begin
            val = CNT_W'(wait_cycles - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised data storage: one port, byte-lane write mask, synchronous read. Not reset.
module dmem_word_array
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Enabled access: write the selected lanes, or register the addressed word for a read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-memory port: one request at a time over valid/ready,
// a fixed number of wait states, byte-enabled stores, registered load data and error flag.
module data_mem_responder
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_en_q;

    logic             req_we_q;
    logic [31:0]      req_addr_q;
    logic [31:0]      req_wdata_q;
    logic [3:0]       req_be_q;

    logic             rsp_err_q;
    logic             rsp_load_q;

    logic             accept;
    logic             rsp_done;
    logic             enter_resp;

    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic             cur_err;

    logic             mem_en;
    logic [31:0]      mem_rdata;

    assign req_ready = (state_q == IDLE) && ready_en_q;
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid && req_ready;
    assign rsp_done  = rsp_valid && rsp_ready;

    // Select the request being committed: with no wait states it is still on the inputs.
    always_comb begin
        cur_we    = req_we_q;
        cur_addr  = req_addr_q;
        cur_wdata = req_wdata_q;
        cur_be    = req_be_q;
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
    end

    // Misaligned, or beyond the array: high address bits are checked, never aliased.
    assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= DEPTH_LIMIT);
    assign mem_en  = enter_resp && !cur_err;

    // Hold off acceptance until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; enter_resp marks the edge that commits the storage access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = wait_load(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture the request on accept; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
        end else if (accept) begin
            req_we_q    <= req_we;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            req_be_q    <= req_be;
        end
    end

    // Response flags: set when entering RESP, cleared once the response is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q  <= cur_err;
            rsp_load_q <= !cur_err && !cur_we;
        end else if (rsp_done) begin
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end
    end

    // Array read data only changes on a read, so it holds while the response is stalled.
    assign rsp_rdata = rsp_load_q ? mem_rdata : 32'h0;
    assign rsp_err   = rsp_err_q;

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (cur_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (mem_rdata)
    );

endmodule
